// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan block: active-low segment
// patterns (dp in bit 7, g..a in bits 6:0) and the number of display positions.
package seg_pkg;

    localparam int NUM_POS = 6;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/seg_scan_if.sv
// Digit bundle coming from the digit-split stage plus the multiplexed display
// drive going out to the common-anode module.
interface seg_scan_if;
    import seg_pkg::*;

    logic               load;
    logic [3:0]         thd;
    logic [3:0]         hud;
    logic [3:0]         ten;
    logic [3:0]         one;
    logic               neg;
    logic               lz_en;
    logic [NUM_POS-1:0] sel;
    logic [7:0]         seg;
    logic               scan_done;

    modport master (
        output load, thd, hud, ten, one, neg, lz_en,
        input  sel, seg, scan_done
    );

    modport slave (
        input  load, thd, hud, ten, one, neg, lz_en,
        output sel, seg, scan_done
    );

endinterface

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment pattern; codes 10..15 render as blank.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] pattern
);

    // Table lookup for legal digits, blank for anything out of range
    always_comb begin
        pattern = SEG_BLANK;
        if (bcd <= 4'd9) begin
            pattern = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Six-position multiplexed display driver. Digits are captured into shadow
// registers on load; each slot lasts SCAN_DIV cycles and starts with a
// BLANK_CYC window where every position is disabled to suppress ghosting.
// sel/seg/scan_done are registered, so they trail the scan state by one cycle.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    seg_scan_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int POS_W = $clog2(NUM_POS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_POS - 1);

    logic [3:0]         sh_thd;
    logic [3:0]         sh_hud;
    logic [3:0]         sh_ten;
    logic [3:0]         sh_one;
    logic               sh_neg;
    logic               sh_lz;

    logic [CNT_W-1:0]   cnt;
    logic [POS_W-1:0]   pos;

    logic [1:0]         msd;
    logic [3:0]         digit_mux;
    logic [7:0]         digit_code;
    logic [7:0]         seg_next;

    logic [NUM_POS-1:0] sel_q;
    logic [7:0]         seg_q;
    logic               done_q;

    // Shadow registers: the display only ever reads these, never the live inputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh_thd <= '0;
            sh_hud <= '0;
            sh_ten <= '0;
            sh_one <= '0;
            sh_neg <= 1'b0;
            sh_lz  <= 1'b1;
        end else if (bus.load) begin
            sh_thd <= bus.thd;
            sh_hud <= bus.hud;
            sh_ten <= bus.ten;
            sh_one <= bus.one;
            sh_neg <= bus.neg;
            sh_lz  <= bus.lz_en;
        end
    end

    // Slot timer and position index; pos steps once per completed slot
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            pos <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Most significant shown digit, and digit selection for the current position
    always_comb begin
        msd = 2'd0;
        if (!sh_lz || (sh_thd != 4'd0)) begin
            msd = 2'd3;
        end else if (sh_hud != 4'd0) begin
            msd = 2'd2;
        end else if (sh_ten != 4'd0) begin
            msd = 2'd1;
        end

        case (pos)
            POS_W'(0): digit_mux = sh_one;
            POS_W'(1): digit_mux = sh_ten;
            POS_W'(2): digit_mux = sh_hud;
            POS_W'(3): digit_mux = sh_thd;
            default:   digit_mux = 4'd0;
        endcase
    end

    seg_decode u_decode (
        .bcd     (digit_mux),
        .pattern (digit_code)
    );

    // Digit up to msd, minus sign (or blank) right above it, blank beyond
    always_comb begin
        seg_next = SEG_BLANK;
        if (pos <= {1'b0, msd}) begin
            seg_next = digit_code;
        end else if ((pos == ({1'b0, msd} + 3'd1)) && sh_neg) begin
            seg_next = SEG_MINUS;
        end
    end

    // Registered display drive and end-of-frame pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q  <= '1;
            seg_q  <= SEG_BLANK;
            done_q <= 1'b0;
        end else begin
            sel_q  <= (cnt < BLANK_END) ? '1 : ~(NUM_POS'(1) << pos);
            seg_q  <= seg_next;
            done_q <= (cnt == CNT_MAX) && (pos == POS_LAST);
        end
    end

    assign bus.sel       = sel_q;
    assign bus.seg       = seg_q;
    assign bus.scan_done = done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with a short slot (SCAN_DIV=4, BLANK_CYC=1). A reference
// model derives the expected display text from the loaded digits and the
// elapsed cycle count; directed frames pin that model with literal patterns.
module tb_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = SCAN_DIV * 6;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    seg_scan_if bus();

    seg_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // Free-running clock
    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: cycles since reset, captured digits, and digits in use
    int          m_k;
    logic [15:0] m_dig;
    logic        m_neg;
    logic        m_lz;
    logic [15:0] u_dig;
    logic        u_neg;
    logic        u_lz;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] code_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Display text: ndig digits from the right, then optional minus, then blanks
    function automatic logic [7:0] exp_seg_f(input int slot, input logic [15:0] dg,
                                             input logic ng, input logic lz);
        int ndig;
        ndig = 4;
        if (lz) begin
            ndig = 1;
            for (int i = 1; i < 4; i++) begin
                if (dg[i*4 +: 4] != 4'd0) ndig = i + 1;
            end
        end
        if (slot < ndig) return code_of(dg[slot*4 +: 4]);
        if ((slot == ndig) && ng) return 8'hBF;
        return 8'hFF;
    endfunction

    // Reference model bookkeeping, advanced on each clock like the DUT's view of time
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_k   <= 0;
            m_dig <= '0;
            m_neg <= 1'b0;
            m_lz  <= 1'b1;
            u_dig <= '0;
            u_neg <= 1'b0;
            u_lz  <= 1'b1;
        end else begin
            m_k   <= m_k + 1;
            u_dig <= m_dig;
            u_neg <= m_neg;
            u_lz  <= m_lz;
            if (bus.load) begin
                m_dig <= {bus.thd, bus.hud, bus.ten, bus.one};
                m_neg <= bus.neg;
                m_lz  <= bus.lz_en;
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge sys_clk) begin : compare
        int          t;
        int          slot;
        int          phase;
        logic [5:0]  e_sel;
        if (chk_en && sys_rst_n) begin
            if (m_k == 0) begin
                check_output("idle_sel", bus.sel, 6'h3F);
                check_output("idle_seg", bus.seg, 8'hFF);
                check_output("idle_done", bus.scan_done, 1'b0);
            end else begin
                t     = m_k - 1;
                slot  = (t / SCAN_DIV) % 6;
                phase = t % SCAN_DIV;
                e_sel = (phase < BLANK_CYC) ? 6'h3F : ~(6'b1 << slot);
                check_output("model_sel", bus.sel, e_sel);
                check_output("model_seg", bus.seg, exp_seg_f(slot, u_dig, u_neg, u_lz));
                check_output("model_done", bus.scan_done, (m_k % FRAME) == 0);
            end
        end
    end

    // Wait (bounded) for a negedge where the model cycle count hits a frame offset
    task automatic align_to(input int offset, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        @(negedge sys_clk);
        while ((m_k % FRAME) != offset && n < 3 * FRAME) begin
            @(negedge sys_clk);
            n++;
        end
        if ((m_k % FRAME) == offset) begin
            ok = 1'b1;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL align: got offset %0d expected %0d", m_k % FRAME, offset);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] t_thd, input logic [3:0] t_hud,
                                  input logic [3:0] t_ten, input logic [3:0] t_one,
                                  input logic t_neg, input logic t_lz);
        @(negedge sys_clk);
        bus.thd   = t_thd;
        bus.hud   = t_hud;
        bus.ten   = t_ten;
        bus.one   = t_one;
        bus.neg   = t_neg;
        bus.lz_en = t_lz;
        bus.load  = 1'b1;
        @(negedge sys_clk);
        bus.load  = 1'b0;
    endtask

    // Sample each slot once (second cycle of the slot) and compare to literals
    task automatic capture_frame(input string tag, input logic [47:0] frame);
        bit         ok;
        logic [5:0] e_sel;
        align_to(2, ok);
        if (ok) begin
            for (int s = 0; s < 6; s++) begin
                e_sel = ~(6'b1 << s);
                check_output($sformatf("%s_slot%0d_seg", tag, s), bus.seg, frame[s*8 +: 8]);
                check_output($sformatf("%s_slot%0d_sel", tag, s), bus.sel, e_sel);
                repeat (SCAN_DIV) @(negedge sys_clk);
            end
        end
    endtask

    initial begin : stimulus
        bit ok;
        int pulses;

        bus.load  = 1'b0;
        bus.thd   = '0;
        bus.hud   = '0;
        bus.ten   = '0;
        bus.one   = '0;
        bus.neg   = 1'b0;
        bus.lz_en = 1'b0;

        // Held in reset
        repeat (3) @(negedge sys_clk);
        check_output("rst_sel", bus.sel, 6'h3F);
        check_output("rst_seg", bus.seg, 8'hFF);
        check_output("rst_done", bus.scan_done, 1'b0);
        sys_rst_n = 1'b1;
        chk_en    = 1'b1;

        // Reset contents: a lone "0"
        capture_frame("reset", 48'hFFFF_FFFF_FFC0);
        check_output("slot0_sel_literal", 6'h3E, 6'h3E ^ (bus.sel & 6'h00));

        // 1234
        apply_stimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
        capture_frame("v1234", 48'hFFFF_F9A4_B099);

        pulses = 0;
        repeat (2 * FRAME) begin
            @(negedge sys_clk);
            if (bus.scan_done) pulses++;
        end
        check_output("done_pulses", pulses, 2);

        // -42 with and without leading-zero blanking
        apply_stimulus(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 1'b1);
        capture_frame("neg42_lz", 48'hFFFF_FFBF_99A4);
        apply_stimulus(4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 1'b0);
        capture_frame("neg42_nolz", 48'hFFBF_C0C0_99A4);

        // "-0"
        apply_stimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        capture_frame("neg0", 48'hFFFF_FFFF_BFC0);

        // Mid-slot reload: new value shows one cycle after the load edge
        align_to(6, ok);
        if (ok) begin
            bus.thd = 4'd7; bus.hud = 4'd0; bus.ten = 4'd0; bus.one = 4'd5;
            bus.neg = 1'b0; bus.lz_en = 1'b1; bus.load = 1'b1;
            @(negedge sys_clk);
            bus.load = 1'b0;
            check_output("reload_old_seg", bus.seg, 8'hBF);
            check_output("reload_old_sel", bus.sel, 6'h3D);
            @(negedge sys_clk);
            check_output("reload_new_seg", bus.seg, 8'hC0);
            check_output("reload_new_sel", bus.sel, 6'h3D);
        end

        // Load on the slot-change edge: the new slot already uses it
        align_to(3, ok);
        if (ok) begin
            bus.thd = 4'd0; bus.hud = 4'd0; bus.ten = 4'd8; bus.one = 4'd6;
            bus.neg = 1'b0; bus.lz_en = 1'b0; bus.load = 1'b1;
            @(negedge sys_clk);
            bus.load = 1'b0;
            check_output("edge_load_prev_seg", bus.seg, 8'h92);
            @(negedge sys_clk);
            check_output("edge_load_new_seg", bus.seg, 8'h80);
            check_output("edge_load_blank_sel", bus.sel, 6'h3F);
        end

        // Invalid BCD renders blank
        apply_stimulus(4'd0, 4'd0, 4'd0, 4'hC, 1'b0, 1'b1);
        capture_frame("bad_lz", 48'hFFFF_FFFF_FFFF);
        apply_stimulus(4'd1, 4'd0, 4'd0, 4'hC, 1'b1, 1'b0);
        capture_frame("bad_nolz", 48'hFFBF_F9C0_C0FF);

        // Load held high with a changing value every cycle
        @(negedge sys_clk);
        for (int i = 0; i < 12; i++) begin
            bus.thd   = 4'(i % 10);
            bus.hud   = 4'((i * 3) % 10);
            bus.ten   = 4'((i * 7) % 11);
            bus.one   = 4'((i * 5) % 10);
            bus.neg   = i[0];
            bus.lz_en = i[1];
            bus.load  = 1'b1;
            @(negedge sys_clk);
        end
        bus.load = 1'b0;
        repeat (FRAME) @(negedge sys_clk);

        // Asynchronous reset in the middle of slot 3
        apply_stimulus(4'd5, 4'd6, 4'd7, 4'd8, 1'b1, 1'b0);
        align_to(14, ok);
        if (ok) begin
            check_output("pre_reset_sel", bus.sel, 6'h37);
            #2;
            chk_en    = 1'b0;
            sys_rst_n = 1'b0;
            #1;
            check_output("async_rst_sel", bus.sel, 6'h3F);
            check_output("async_rst_seg", bus.seg, 8'hFF);
            check_output("async_rst_done", bus.scan_done, 1'b0);
            repeat (2) @(negedge sys_clk);
            sys_rst_n = 1'b1;
            chk_en    = 1'b1;
            capture_frame("post_reset", 48'hFFFF_FFFF_FFC0);
        end

        repeat (2) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
